example_sdiv_seq_21s_10s: RTL and testbench
===========================================

EXAMPLE_SDIV_SEQ_21S_10S -- requirements
Module: example_sdiv_seq_21s_10s

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 21, dividend width (signed).
REQ-002 SHALL have parameter din1_WIDTH, default 10, divisor width (signed).
REQ-003 SHALL have parameter dout_WIDTH, default 14, quotient width (signed).
REQ-004 SHALL have port ap_clk, input, 1, the only clock; all state on its rising edge.
REQ-005 SHALL have port ap_rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port ap_start, input, 1, request; operands valid while high.
REQ-007 SHALL have port ap_ready, output, 1, one-cycle pulse on the cycle operands are accepted.
REQ-008 SHALL have port ap_idle, output, 1, high when in IDLE.
REQ-009 SHALL have port ap_done, output, 1, one-cycle pulse when results are valid.
REQ-010 SHALL have port din0, input, din0_WIDTH, signed dividend.
REQ-011 SHALL have port din1, input, din1_WIDTH, signed divisor.
REQ-012 SHALL have port dout, output, dout_WIDTH, signed quotient.
REQ-013 SHALL have port rem, output, din1_WIDTH, signed remainder.
REQ-014 SHALL have port ovf, output, 1, quotient saturated (not representable in dout_WIDTH).
REQ-015 SHALL have port dbz, output, 1, divisor was zero.

Function
REQ-016 SHALL implement states IDLE, CALC, FIXUP, DONE; IDLE->CALC on ap_start, CALC->FIXUP after din0_WIDTH iterations, FIXUP->DONE, DONE->IDLE unconditionally.
REQ-017 SHALL accept operands only in IDLE with ap_start=1, registering din0/din1 and asserting ap_ready in that cycle T; ap_start outside IDLE ignored.
REQ-018 SHALL compute on magnitudes with a restoring algorithm, one quotient bit per CALC cycle, MSB first, with a din0_WIDTH-bit counter.
REQ-019 SHALL have fixed latency: ap_done=1 at cycle T+din0_WIDTH+2 (T+23 at defaults) for every operand pair including divide-by-zero.
REQ-020 SHALL truncate toward zero: quotient negative iff operand signs differ and quotient nonzero; remainder carries dividend's sign; din0 = q*din1 + rem when not ovf/dbz.
REQ-021 SHALL handle magnitude of most-negative dividend (2^(din0_WIDTH-1)) without loss; internal magnitude register din0_WIDTH bits unsigned.
REQ-022 SHALL, if the true quotient lies outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1], saturate dout to the nearer bound, set ovf=1, still output the true remainder.
REQ-023 SHALL, if din1=0, output dout = max positive when din0>=0 else min negative, rem=0, dbz=1, ovf=0.
REQ-024 SHALL update dout/rem/ovf/dbz in FIXUP, hold them stable from ap_done until the next FIXUP.
REQ-025 SHALL permit back-to-back: ap_start held high restarts in the IDLE cycle after DONE (throughput one result per din0_WIDTH+3 cycles).
REQ-026 SHALL keep ap_idle=0 from cycle T+1 through DONE, 1 in IDLE.

Reset
REQ-027 SHALL, on ap_rst=1 at any time including mid-CALC, asynchronously force state IDLE, counter 0, dout/rem/ovf/dbz/ap_ready/ap_done=0, ap_idle=1; operation in flight is discarded with no ap_done.
REQ-028 SHALL accept a new ap_start in the first cycle after ap_rst deasserts.

Structure
REQ-029 SHALL place default widths and the state encoding (IDLE, CALC, FIXUP, DONE) in shared package example_sdiv_pkg.
REQ-030 SHALL instantiate one sub-module example_udiv_step: combinational single restoring step (partial remainder, divisor magnitude -> next remainder, quotient bit); sign handling, saturation and FSM stay in top.

Verification
REQ-031 SHALL test din0=1000, din1=7 -> ap_done at T+23, dout=142, rem=6, ovf=0, dbz=0.
REQ-032 SHALL test sign cases -1000/7 -> dout=-142, rem=-6; 1000/-7 -> dout=-142, rem=6; -1000/-7 -> dout=142, rem=-6.
REQ-033 SHALL test din0=1048575, din1=1 -> dout=8191, ovf=1, rem=0; din0=-1048576, din1=-512 -> dout=2048, rem=0, ovf=0.
REQ-034 SHALL test din0=-5, din1=0 -> dout=-8192, rem=0, dbz=1, ap_done at T+23.
REQ-035 SHALL test ap_start held high for 60 cycles -> ap_ready at T and T+24, ap_done at T+23 and T+47, operand changes during CALC ignored.
REQ-036 SHALL test ap_rst asserted at T+10 -> outputs 0, ap_idle=1 immediately, no ap_done; next request 100/3 -> dout=33, rem=1.

Source files
------------

// File: rtl/example_sdiv_pkg.sv
// -----------------------------------------------------------------------------
// example_sdiv_pkg
// Shared definitions for the sequential signed divider: default operand and
// result widths, and the controller state encoding.
// -----------------------------------------------------------------------------
package example_sdiv_pkg;

    // Default widths: 21-bit signed dividend, 10-bit signed divisor,
    // 14-bit signed quotient.
    localparam int DIN0_WIDTH_DEF = 21;
    localparam int DIN1_WIDTH_DEF = 10;
    localparam int DOUT_WIDTH_DEF = 14;

    // Controller states. One quotient bit is produced per CALC cycle;
    // FIXUP applies signs and saturation; DONE presents the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : example_sdiv_pkg

// File: rtl/example_sdiv_seq_21s_10s_if.sv
// -----------------------------------------------------------------------------
// example_sdiv_seq_21s_10s_if
// Groups the request/response handshake and operand/result buses of the
// sequential signed divider.
//   master : issues requests (drives ap_start, din0, din1)
//   slave  : the divider (drives ap_ready, ap_idle, ap_done, dout, rem, ovf, dbz)
// -----------------------------------------------------------------------------
interface example_sdiv_seq_21s_10s_if
    import example_sdiv_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_WIDTH_DEF,
    parameter int din1_WIDTH = DIN1_WIDTH_DEF,
    parameter int dout_WIDTH = DOUT_WIDTH_DEF
);
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_idle;
    logic                  ap_done;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output ap_start, din0, din1,
        input  ap_ready, ap_idle, ap_done, dout, rem, ovf, dbz
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_ready, ap_idle, ap_done, dout, rem, ovf, dbz
    );

endinterface : example_sdiv_seq_21s_10s_if

// File: rtl/example_udiv_step.sv
// -----------------------------------------------------------------------------
// example_udiv_step
// One combinational restoring-division step on unsigned magnitudes.
//   i_rem : current partial remainder (always < i_div when i_div != 0)
//   i_bit : next dividend bit, MSB first
//   i_div : divisor magnitude
//   o_rem : next partial remainder
//   o_q   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module example_udiv_step #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;

    assign w_shift = {i_rem, i_bit};
    assign o_q     = (w_shift >= {1'b0, i_div});

    // The restored remainder is always below i_div, so the low WIDTH bits of
    // the subtraction are exact even though w_shift may need WIDTH+1 bits.
    assign o_rem = o_q ? (w_shift[WIDTH-1:0] - i_div) : w_shift[WIDTH-1:0];

endmodule : example_udiv_step

// File: rtl/example_sdiv_seq_21s_10s.sv
// -----------------------------------------------------------------------------
// example_sdiv_seq_21s_10s
// Sequential signed divider, truncating toward zero, fixed latency.
// Operands are accepted in IDLE when ap_start is high (ap_ready pulses that
// cycle T); ap_done pulses at T+din0_WIDTH+2 with dout/rem/ovf/dbz valid, and
// those results hold until the next operation's FIXUP cycle.
//   ap_clk, ap_rst     : clock, asynchronous active-high reset
//   ap_start           : request, operands valid while high
//   ap_ready/idle/done : handshake status
//   din0, din1         : signed dividend, signed divisor
//   dout, rem          : signed quotient (saturated), signed remainder
//   ovf                : quotient saturated to dout_WIDTH
//   dbz                : divisor was zero
// -----------------------------------------------------------------------------
module example_sdiv_seq_21s_10s
    import example_sdiv_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_WIDTH_DEF,
    parameter int din1_WIDTH = DIN1_WIDTH_DEF,
    parameter int dout_WIDTH = DOUT_WIDTH_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1);

    // Saturation bounds for dout, and the quotient magnitudes they correspond
    // to (the negative bound has one more unit of magnitude than the positive).
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [din0_WIDTH-1:0] QMAG_POS_LIM =
        {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] QMAG_NEG_LIM =
        {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;

    // r_dvd starts as the dividend magnitude; each CALC step shifts one
    // dividend bit out of the top and one quotient bit into the bottom, so it
    // holds the quotient magnitude once CALC finishes.
    logic [din0_WIDTH-1:0] r_dvd;
    logic [din1_WIDTH-1:0] r_dsr;      // divisor magnitude
    logic [din1_WIDTH-1:0] r_prem;     // partial remainder
    logic                  r_neg_q;    // operand signs differ
    logic                  r_neg_d0;   // dividend negative (remainder sign)
    logic                  r_div_zero;

    logic [dout_WIDTH-1:0] r_dout;
    logic [din1_WIDTH-1:0] r_rem;
    logic                  r_ovf;
    logic                  r_dbz;

    logic [din0_WIDTH-1:0] w_din0_mag;
    logic [din1_WIDTH-1:0] w_din1_mag;
    logic [din1_WIDTH-1:0] w_step_rem;
    logic                  w_step_q;
    logic [dout_WIDTH-1:0] w_dout_fix;
    logic [din1_WIDTH-1:0] w_rem_fix;
    logic                  w_ovf_fix;

    // Negating the most-negative value yields 2^(W-1) as an unsigned W-bit
    // magnitude, which is exactly what the unsigned datapath needs.
    assign w_din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
    assign w_din1_mag = din1[din1_WIDTH-1] ? -din1 : din1;

    example_udiv_step #(
        .WIDTH (din1_WIDTH)
    ) u_step (
        .i_rem (r_prem),
        .i_bit (r_dvd[din0_WIDTH-1]),
        .i_div (r_dsr),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // ---------------------------------------------------------------- FSM ---
    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ap_start) w_state_nxt = CALC;
            CALC:    if (r_cnt == CNT_LAST) w_state_nxt = FIXUP;
            FIXUP:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ap_ready is also gated by ap_rst so it stays low while reset is held.
    always_comb begin
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (r_state)
            IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start & ~ap_rst;
            end
            DONE:    ap_done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------- result fixup ---
    always_comb begin
        w_dout_fix = '0;
        w_rem_fix  = '0;
        w_ovf_fix  = 1'b0;
        if (r_div_zero) begin
            w_dout_fix = r_neg_d0 ? DOUT_MIN : DOUT_MAX;
        end else begin
            w_rem_fix = r_neg_d0 ? -r_prem : r_prem;
            if (r_neg_q) begin
                if (r_dvd > QMAG_NEG_LIM) begin
                    w_dout_fix = DOUT_MIN;
                    w_ovf_fix  = 1'b1;
                end else begin
                    w_dout_fix = -r_dvd[dout_WIDTH-1:0];
                end
            end else begin
                if (r_dvd > QMAG_POS_LIM) begin
                    w_dout_fix = DOUT_MAX;
                    w_ovf_fix  = 1'b1;
                end else begin
                    w_dout_fix = r_dvd[dout_WIDTH-1:0];
                end
            end
        end
    end

    // ----------------------------------------------------------- datapath ---
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_prem     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_d0   <= 1'b0;
            r_div_zero <= 1'b0;
            r_dout     <= '0;
            r_rem      <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_dvd      <= w_din0_mag;
                        r_dsr      <= w_din1_mag;
                        r_prem     <= '0;
                        r_cnt      <= '0;
                        r_neg_q    <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        r_neg_d0   <= din0[din0_WIDTH-1];
                        r_div_zero <= (din1 == '0);
                    end
                end
                CALC: begin
                    r_dvd  <= {r_dvd[din0_WIDTH-2:0], w_step_q};
                    r_prem <= w_step_rem;
                    r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                FIXUP: begin
                    r_dout <= w_dout_fix;
                    r_rem  <= w_rem_fix;
                    r_ovf  <= w_ovf_fix;
                    r_dbz  <= r_div_zero;
                end
                default: ;
            endcase
        end
    end

    assign dout = r_dout;
    assign rem  = r_rem;
    assign ovf  = r_ovf;
    assign dbz  = r_dbz;

endmodule : example_sdiv_seq_21s_10s

// File: tb/tb_example_sdiv_seq_21s_10s.sv
// -----------------------------------------------------------------------------
// tb_example_sdiv_seq_21s_10s
// Self-checking bench for the sequential signed divider. Expected results come
// from plain integer division (truncating) plus saturation rules.
// -----------------------------------------------------------------------------
module tb_example_sdiv_seq_21s_10s;
    import example_sdiv_pkg::*;

    localparam int D0W = DIN0_WIDTH_DEF;
    localparam int D1W = DIN1_WIDTH_DEF;
    localparam int DW  = DOUT_WIDTH_DEF;
    localparam int LAT = D0W + 2;

    localparam longint QMAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam longint QMIN = -(64'sd1 <<< (DW - 1));

    logic ap_clk;
    logic ap_rst;

    int checks   = 0;
    int failures = 0;

    example_sdiv_seq_21s_10s_if #(
        .din0_WIDTH (D0W),
        .din1_WIDTH (D1W),
        .dout_WIDTH (DW)
    ) bus ();

    example_sdiv_seq_21s_10s #(
        .din0_WIDTH (D0W),
        .din1_WIDTH (D1W),
        .dout_WIDTH (DW)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (bus.ap_start),
        .ap_ready (bus.ap_ready),
        .ap_idle  (bus.ap_idle),
        .ap_done  (bus.ap_done),
        .din0     (bus.din0),
        .din1     (bus.din1),
        .dout     (bus.dout),
        .rem      (bus.rem),
        .ovf      (bus.ovf),
        .dbz      (bus.dbz)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: truncating signed division with saturation and divide-by-zero rules.
    function automatic void model(input longint a, input longint b,
                                  output longint q, output longint r,
                                  output logic o, output logic z);
        o = 1'b0;
        z = 1'b0;
        r = 0;
        if (b == 0) begin
            z = 1'b1;
            q = (a >= 0) ? QMAX : QMIN;
        end else begin
            q = a / b;
            r = a % b;
            if (q > QMAX) begin
                q = QMAX;
                o = 1'b1;
            end else if (q < QMIN) begin
                q = QMIN;
                o = 1'b1;
            end
        end
    endfunction

    function automatic longint sx0(input logic [D0W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx1(input logic [D1W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Issues one request and follows it to ap_done. With no_wait set the
    // request is driven in the current (negedge) time step.
    task automatic run_op(input string tag, input longint a, input longint b,
                          input bit no_wait);
        longint eq, er;
        logic   eo, ez;
        int     done_at;
        int     idle_bad;
        if (!no_wait) @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = a[D0W-1:0];
        bus.din1     = b[D1W-1:0];
        #1;
        check({tag, "_ready"}, bus.ap_ready, 1);
        model(sx0(a[D0W-1:0]), sx1(b[D1W-1:0]), eq, er, eo, ez);
        done_at  = -1;
        idle_bad = 0;
        for (int k = 1; k <= LAT + 8 && done_at < 0; k++) begin
            @(negedge ap_clk);
            bus.ap_start = 1'b0;
            bus.din0     = D0W'($urandom);
            bus.din1     = D1W'($urandom);
            #1;
            if (bus.ap_done) done_at = k;
            else if (bus.ap_idle) idle_bad++;
        end
        check({tag, "_latency"}, done_at, LAT);
        check({tag, "_idle_busy"}, idle_bad, 0);
        if (done_at > 0) begin
            check({tag, "_dout"}, $signed(bus.dout), eq);
            check({tag, "_rem"}, $signed(bus.rem), er);
            check({tag, "_ovf"}, bus.ovf, eo);
            check({tag, "_dbz"}, bus.dbz, ez);
            @(negedge ap_clk);
            #1;
            check({tag, "_done_pulse"}, bus.ap_done, 0);
            check({tag, "_hold"}, $signed(bus.dout), eq);
        end
    endtask

    // ap_start held high for 60 cycles with operands changing every cycle.
    task automatic back_to_back();
        longint a_q[$];
        longint b_q[$];
        longint a, b, eq, er;
        logic   eo, ez;
        int     n_ready = 0;
        int     n_done  = 0;
        @(negedge ap_clk);
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge ap_clk);
            bus.ap_start = (k < 60);
            bus.din0     = D0W'($urandom);
            bus.din1     = D1W'($urandom_range(40, 1));
            #1;
            if (bus.ap_ready) begin
                n_ready++;
                check("b2b_ready_at", k % (LAT + 1), 0);
                a_q.push_back(sx0(bus.din0));
                b_q.push_back(sx1(bus.din1));
            end
            if (bus.ap_done) begin
                n_done++;
                check("b2b_done_at", k % (LAT + 1), LAT);
                if (a_q.size() > 0) begin
                    a = a_q.pop_front();
                    b = b_q.pop_front();
                    model(a, b, eq, er, eo, ez);
                    check("b2b_dout", $signed(bus.dout), eq);
                    check("b2b_rem", $signed(bus.rem), er);
                    check("b2b_ovf", bus.ovf, eo);
                end
            end
        end
        check("b2b_n_ready", n_ready, 3);
        check("b2b_n_done", n_done, 3);
    endtask

    initial begin
        longint a, b;
        int     n_done;
        ap_rst       = 1'b1;
        bus.ap_start = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        #1;
        check("rst_idle", bus.ap_idle, 1);
        check("rst_ready", bus.ap_ready, 0);
        check("rst_done", bus.ap_done, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_rem", bus.rem, 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run_op("p_p", 1000, 7, 1'b1);
        run_op("n_p", -1000, 7, 1'b0);
        run_op("p_n", 1000, -7, 1'b0);
        run_op("n_n", -1000, -7, 1'b0);
        run_op("ovf_max", 1048575, 1, 1'b0);
        run_op("minneg", -1048576, -512, 1'b0);
        run_op("ovf_min", -1048576, 1, 1'b0);
        run_op("negmin_ok", -8192, 1, 1'b0);
        run_op("dbz_neg", -5, 0, 1'b0);
        run_op("dbz_pos", 5, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = sx0(D0W'($urandom));
            if (i % 3 == 0) b = longint'($urandom_range(16, 0)) - 8;
            else            b = sx1(D1W'($urandom));
            run_op("rand", a, b, 1'b0);
        end

        back_to_back();

        // Reset in the middle of CALC: results cleared at once, no ap_done.
        run_op("pre_rst", 1000, 7, 1'b0);
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = D0W'(12345);
        bus.din1     = D1W'(11);
        for (int k = 1; k <= 10; k++) begin
            @(negedge ap_clk);
            bus.ap_start = 1'b0;
        end
        ap_rst = 1'b1;
        #1;
        check("mid_rst_idle", bus.ap_idle, 1);
        check("mid_rst_done", bus.ap_done, 0);
        check("mid_rst_dout", bus.dout, 0);
        check("mid_rst_rem", bus.rem, 0);
        check("mid_rst_ovf", bus.ovf, 0);
        check("mid_rst_dbz", bus.dbz, 0);
        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            #1;
            if (bus.ap_done) n_done++;
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run_op("post_rst", 100, 3, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge ap_clk);
            #1;
            if (bus.ap_done) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_example_sdiv_seq_21s_10s
